// File: rtl/mlp_pkg.sv
// Shared widths, FSM state encoding and weight-index map for the 2-2-1 threshold MLP sequencer.
package mlp_pkg;

    localparam int COEF_W    = 4;
    localparam int SUM_W     = 6;
    localparam int WRAP_W    = 4;
    localparam int ADDR_W    = 4;
    localparam int N_WEIGHTS = 9;

    // Each node owns three consecutive weights: wA, wB, bias.
    localparam int NODE_A_BASE = 0;
    localparam int NODE_B_BASE = 3;
    localparam int NODE_C_BASE = 6;
    localparam int W_OFS_A     = 0;
    localparam int W_OFS_B     = 1;
    localparam int W_OFS_BIAS  = 2;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NODE_A = 3'd1,
        NODE_B = 3'd2,
        NODE_C = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/neuron_pe.sv
// Combinational threshold neuron: sum = in1*wA + in2*wB - bias, act = (sum > 0).
// Macro MLP_SEQ_WRAP4_EN wraps the sum to 4-bit signed before thresholding.
module neuron_pe
    import mlp_pkg::*;
(
    input  logic  in1_i,
    input  logic  in2_i,
    input  coef_t wa_i,
    input  coef_t wb_i,
    input  coef_t bias_i,
    output sum_t  sum_o,
    output logic  act_o
);

    function automatic sum_t sext_coef(input coef_t c);
        return {{(SUM_W-COEF_W){c[COEF_W-1]}}, c};
    endfunction

`ifdef MLP_SEQ_WRAP4_EN
    function automatic sum_t wrap_sum(input sum_t s);
        return {{(SUM_W-WRAP_W){s[WRAP_W-1]}}, s[WRAP_W-1:0]};
    endfunction
`endif

    sum_t term_a;
    sum_t term_b;
    sum_t full_sum;

    always_comb begin
        term_a   = in1_i ? sext_coef(wa_i) : '0;
        term_b   = in2_i ? sext_coef(wb_i) : '0;
        // Operand range keeps the result within -23..+22, so 6 bits never overflow.
        full_sum = term_a + term_b - sext_coef(bias_i);
`ifdef MLP_SEQ_WRAP4_EN
        sum_o    = wrap_sum(full_sum);
`else
        sum_o    = full_sum;
`endif
        act_o    = !sum_o[SUM_W-1] && (sum_o != '0);
    end

endmodule

// File: rtl/mlp_sequencer.sv
// 2-2-1 threshold network evaluated node by node (A, B, C) on one shared neuron_pe.
// Build with MLP_SEQ_WRAP4_EN for the legacy 4-bit wrap-around sum.
module mlp_sequencer
    import mlp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    output logic                    wr_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    y,
    output logic signed [SUM_W-1:0] sum_dbg,
    output logic                    busy
);

    state_e state_q, state_d;
    coef_t  w_q [N_WEIGHTS];
    logic [1:0] x_q;
    logic   ha_q;
    logic   hb_q;
    logic   y_q;
    sum_t   sum_q;

    logic   idle;
    logic   accept;
    logic   wr_ok;
    logic   pe_in1;
    logic   pe_in2;
    coef_t  pe_wa;
    coef_t  pe_wb;
    coef_t  pe_bias;
    sum_t   pe_sum;
    logic   pe_act;

    assign idle      = (state_q == IDLE);
    assign accept    = in_valid && idle;
    assign wr_ok     = wr_en && idle;
    assign wr_ready  = idle;
    assign in_ready  = idle;
    assign busy      = !idle;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign sum_dbg   = sum_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = NODE_A;
            NODE_A:  state_d = NODE_B;
            NODE_B:  state_d = NODE_C;
            NODE_C:  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/weight mux for the shared PE; C consumes the registered hidden activations.
    always_comb begin
        pe_in1  = x_q[0];
        pe_in2  = x_q[1];
        pe_wa   = w_q[NODE_A_BASE + W_OFS_A];
        pe_wb   = w_q[NODE_A_BASE + W_OFS_B];
        pe_bias = w_q[NODE_A_BASE + W_OFS_BIAS];
        case (state_q)
            NODE_B: begin
                pe_wa   = w_q[NODE_B_BASE + W_OFS_A];
                pe_wb   = w_q[NODE_B_BASE + W_OFS_B];
                pe_bias = w_q[NODE_B_BASE + W_OFS_BIAS];
            end
            NODE_C: begin
                pe_in1  = ha_q;
                pe_in2  = hb_q;
                pe_wa   = w_q[NODE_C_BASE + W_OFS_A];
                pe_wb   = w_q[NODE_C_BASE + W_OFS_B];
                pe_bias = w_q[NODE_C_BASE + W_OFS_BIAS];
            end
            default: ;
        endcase
    end

    neuron_pe u_pe (
        .in1_i  (pe_in1),
        .in2_i  (pe_in2),
        .wa_i   (pe_wa),
        .wb_i   (pe_wb),
        .bias_i (pe_bias),
        .sum_o  (pe_sum),
        .act_o  (pe_act)
    );

    // Addresses 9..15 match no entry and fall through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WEIGHTS; i++) w_q[i] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < N_WEIGHTS; i++) begin
                if (wr_addr == ADDR_W'(i)) w_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            ha_q  <= 1'b0;
            hb_q  <= 1'b0;
            y_q   <= 1'b0;
            sum_q <= '0;
        end else begin
            if (accept)            x_q <= x;
            if (state_q == NODE_A) ha_q <= pe_act;
            if (state_q == NODE_B) hb_q <= pe_act;
            if (state_q == NODE_C) begin
                y_q   <= pe_act;
                sum_q <= pe_sum;
            end
        end
    end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Randomized and directed self-checking bench for mlp_sequencer against an arithmetic network model.
module tb_mlp_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic signed [3:0] wr_data;
    logic              wr_ready;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        x;
    logic              out_valid;
    logic              out_ready;
    logic              y;
    logic signed [5:0] sum_dbg;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int wm [9];

    mlp_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sum_dbg   (sum_dbg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int node_sum(input int a, input int b, input int wa, input int wb, input int bias);
        int s;
        s = a * wa + b * wb - bias;
`ifdef MLP_SEQ_WRAP4_EN
        s = s & 15;
        if (s >= 8) s = s - 16;
`endif
        return s;
    endfunction

    function automatic void ref_eval(input int x0, input int x1, output int s, output int yo);
        int ha, hb;
        ha = (node_sum(x0, x1, wm[0], wm[1], wm[2]) > 0) ? 1 : 0;
        hb = (node_sum(x0, x1, wm[3], wm[4], wm[5]) > 0) ? 1 : 0;
        s  = node_sum(ha, hb, wm[6], wm[7], wm[8]);
        yo = (s > 0) ? 1 : 0;
    endfunction

    task automatic write_w(input int addr, input int val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = 4'(val);
        @(negedge clk);
        wr_en = 1'b0;
        if (addr < 9) wm[addr] = val;
    endtask

    // mode 0: plain; 1: attempt write w6=-8 during NODE_B; 2: write w2=7 on the accept edge.
    task automatic run(input logic [1:0] xv, input int hold, input int mode, input string tag,
                       output int got_y, output int got_s);
        int es, ey, cyc;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        x        = xv;
        in_valid = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        if (mode == 2) begin
            wr_en   = 1'b1;
            wr_addr = 4'd2;
            wr_data = 4'sd7;
            wm[2]   = 7;
        end
        ref_eval(int'(xv[0]), int'(xv[1]), es, ey);
        @(negedge clk);
        in_valid = 1'b0;
        wr_en    = 1'b0;
        x        = ~xv;
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_ov_a"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_ov_b"}, int'(out_valid), 0);
        if (mode == 1) begin
            chk({tag, "_wr_ready_busy"}, int'(wr_ready), 0);
            wr_en   = 1'b1;
            wr_addr = 4'd6;
            wr_data = -4'sd8;
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk({tag, "_ov_c"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_ov_done"}, int'(out_valid), 1);
        chk({tag, "_y"}, int'(y), ey);
        chk({tag, "_sum"}, int'(sum_dbg), es);
        got_y = int'(y);
        got_s = int'(sum_dbg);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_bp_ov"}, int'(out_valid), 1);
            chk({tag, "_bp_y"}, int'(y), ey);
            chk({tag, "_bp_sum"}, int'(sum_dbg), es);
            chk({tag, "_bp_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ov_clear"}, int'(out_valid), 0);
        chk({tag, "_idle"}, int'(in_ready), 1);
    endtask

    task automatic load(input int w0, input int w1, input int w2, input int w3, input int w4,
                        input int w5, input int w6, input int w7, input int w8);
        int prog [9];
        prog = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};
        for (int i = 0; i < 9; i++) write_w(i, prog[i]);
    endtask

    initial begin
        int gy, gs, cyc;
        int xor_y [4];
        xor_y = '{0, 1, 1, 0};
        for (int i = 0; i < 9; i++) wm[i] = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_sum", int'(sum_dbg), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // XOR program
        load(2, 2, 1, -2, -2, -3, 2, 2, 3);
        for (int i = 0; i < 4; i++) begin
            run(2'(i), 0, 0, "xor", gy, gs);
            chk("xor_y_const", gy, xor_y[i]);
        end
        chk("xor11_sum_const", gs, -1);

        run(2'b01, 5, 0, "bp", gy, gs);
        chk("bp_y_const", gy, 1);

        run(2'b11, 0, 1, "busywr", gy, gs);
        chk("busywr_sum_const", gs, -1);
        run(2'b10, 0, 0, "busywr_after", gy, gs);
        chk("busywr_after_y_const", gy, 1);

        write_w(12, -8);
        for (int i = 0; i < 4; i++) begin
            run(2'(i), 0, 0, "addr12", gy, gs);
            chk("addr12_y_const", gy, xor_y[i]);
        end

        run(2'b11, 0, 2, "simul", gy, gs);
        chk("simul_y_const", gy, 0);
        chk("simul_sum_const", gs, -3);
        write_w(2, 1);

        // Width
        load(2, 2, 1, 2, 2, 1, 7, 7, 0);
        run(2'b11, 0, 0, "width", gy, gs);
`ifdef MLP_SEQ_WRAP4_EN
        chk("width_sum_const", gs, -2);
        chk("width_y_const", gy, 0);
`else
        chk("width_sum_const", gs, 14);
        chk("width_y_const", gy, 1);
`endif

        // Reset in the middle of an evaluation
        load(2, 2, 1, -2, -2, -3, 2, 2, 3);
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        x        = 2'b11;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sum", int'(sum_dbg), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) wm[i] = 0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_out", int'(out_valid), 0);
        end
        run(2'b11, 0, 0, "after_rst", gy, gs);
        chk("after_rst_sum_const", gs, 0);
        chk("after_rst_y_const", gy, 0);

        // Randomized programs and samples
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                write_w(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)) - 8);
            end
            run(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                "rand", gy, gs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "bench timeout");
    end

endmodule
